// File: rtl/log_unit_pipe.sv
// log_unit_pipe: WIDTH-bit bitwise logic unit with a two-stage registered
// datapath, valid/ready handshakes on both sides, zero/parity status flags
// and a wrapping count of results handed downstream.
module log_unit_pipe #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rest,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       alu_fun,
  input  logic             log_EN,
  output logic             in_ready,
  output logic [WIDTH-1:0] log_out,
  output logic             log_flag,
  input  logic             out_ready,
  output logic             zero_flag,
  output logic             par_flag,
  output logic [CNT_W-1:0] done_cnt
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_ANDN = 3'b111;

  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic             s1_valid;
  logic [WIDTH-1:0] result;
  logic             s2_free;
  logic             s1_adv;
  logic             accept;
  logic             drain;

  // Handshake decode: s2 can take new data when empty or draining this cycle.
  always_comb begin
    s2_free  = !log_flag || out_ready;
    s1_adv   = s1_valid && s2_free;
    in_ready = !s1_valid || s2_free;
    accept   = log_EN && in_ready;
    drain    = log_flag && out_ready;
  end

  // Operation decode on the stage-1 registers.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // result unassigned, which would otherwise infer a latch.
    result = '0;
    case (s1_op)
      OP_AND:  result = s1_a & s1_b;
      OP_OR:   result = s1_a | s1_b;
      OP_NAND: result = ~(s1_a & s1_b);
      OP_NOR:  result = ~(s1_a | s1_b);
      OP_XOR:  result = s1_a ^ s1_b;
      OP_XNOR: result = ~(s1_a ^ s1_b);
      OP_NOTA: result = ~s1_a;
      OP_ANDN: result = s1_a & ~s1_b;
      default: result = '0;
    endcase
  end

  // Stage 1: capture operands on input transfer; empty when passed to s2.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, so the two stages shift together without races.
    if (rest) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= A;
      s1_b     <= B;
      s1_op    <= alu_fun;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: register result and flags; hold everything while stalled.
  always_ff @(posedge clk) begin
    if (rest) begin
      log_flag  <= 1'b0;
      log_out   <= '0;
      zero_flag <= 1'b0;
      par_flag  <= 1'b0;
    end else if (s1_adv) begin
      log_flag  <= 1'b1;
      log_out   <= result;
      zero_flag <= ~|result;
      par_flag  <= ^result;
    end else if (out_ready) begin
      log_flag  <= 1'b0;
    end
  end

  // Count every result that transfers out; wraps naturally.
  always_ff @(posedge clk) begin
    if (rest) begin
      done_cnt <= '0;
    end else if (drain) begin
      done_cnt <= done_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_log_unit_pipe.sv
// tb_log_unit_pipe: directed stimulus with hand-computed results pushed into
// a scoreboard queue; a separate monitor compares whatever the unit presents.
module tb_log_unit_pipe;

  typedef struct packed {
    logic [15:0] r;
    logic        z;
    logic        p;
  } exp_t;

  logic        clk = 1'b0;
  logic        rest;
  logic [15:0] A, B;
  logic [2:0]  alu_fun;
  logic        log_EN;
  logic        out_ready;
  logic        in_ready, log_flag, zero_flag, par_flag;
  logic [15:0] log_out, done_cnt;
  logic        in_ready4, log_flag4, zero_flag4, par_flag4;
  logic [15:0] log_out4;
  logic [3:0]  done_cnt4;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int run_len = 0;
  int max_run = 0;
  exp_t sb[$];

  logic [15:0] op_tab [8];

  log_unit_pipe #(.WIDTH(16), .CNT_W(16)) dut (
    .clk(clk), .rest(rest), .A(A), .B(B), .alu_fun(alu_fun),
    .log_EN(log_EN), .in_ready(in_ready), .log_out(log_out),
    .log_flag(log_flag), .out_ready(out_ready), .zero_flag(zero_flag),
    .par_flag(par_flag), .done_cnt(done_cnt)
  );

  log_unit_pipe #(.WIDTH(16), .CNT_W(4)) dut4 (
    .clk(clk), .rest(rest), .A(A), .B(B), .alu_fun(alu_fun),
    .log_EN(log_EN), .in_ready(in_ready4), .log_out(log_out4),
    .log_flag(log_flag4), .out_ready(out_ready), .zero_flag(zero_flag4),
    .par_flag(par_flag4), .done_cnt(done_cnt4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare the presented result against the oldest expectation,
  // every cycle it is valid (so stalls are checked for stability too).
  always @(negedge clk) begin
    if (log_flag === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'(log_out), 32'hDEAD_BEEF);
      end else begin
        check("log_out", 32'(log_out), 32'(sb[0].r));
        check("zero_flag", 32'(zero_flag), 32'(sb[0].z));
        check("par_flag", 32'(par_flag), 32'(sb[0].p));
        if (out_ready === 1'b1) void'(sb.pop_front());
      end
    end
    if (log_flag === 1'b1 && out_ready === 1'b1) run_len++;
    else run_len = 0;
    if (run_len > max_run) max_run = run_len;
  end

  function automatic exp_t mk(input logic [15:0] r);
    mk.r = r;
    mk.z = (r == 16'h0);
    mk.p = ^r;
  endfunction

  // Offer one operation and wait (bounded) for it to be accepted.
  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [2:0] op, input logic [15:0] r);
    int n;
    A = a; B = b; alu_fun = op; log_EN = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      n++;
      if (n > 50) begin
        check("accept_timeout", 32'(in_ready), 32'h1);
        log_EN = 1'b0;
        return;
      end
    end
    sb.push_back(mk(r));
    @(posedge clk); #1;
    log_EN = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rest = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rest = 1'b0;
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    op_tab[0] = 16'hF000; op_tab[1] = 16'hFFF0;
    op_tab[2] = 16'h0FFF; op_tab[3] = 16'h000F;
    op_tab[4] = 16'h0FF0; op_tab[5] = 16'hF00F;
    op_tab[6] = 16'h0F0F; op_tab[7] = 16'h00F0;

    // Reset with a transfer offered: reset must win.
    A = 16'hF0F0; B = 16'hFF00; alu_fun = 3'b000;
    log_EN = 1'b1; out_ready = 1'b1; rest = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rest = 1'b0; log_EN = 1'b0;
    sb.delete();
    @(negedge clk);
    check("rst_log_flag", 32'(log_flag), 32'h0);
    check("rst_log_out", 32'(log_out), 32'h0);
    check("rst_done_cnt", 32'(done_cnt), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_zero_flag", 32'(zero_flag), 32'h0);
    check("rst_par_flag", 32'(par_flag), 32'h0);
    @(posedge clk); #1;

    // All opcodes, isolated, with latency checked.
    for (int i = 0; i < 8; i++) begin
      send(16'hF0F0, 16'hFF00, 3'(i), op_tab[i]);
      @(negedge clk);
      check("latency_not_yet", 32'(log_flag), 32'h0);
      @(negedge clk);
      check("latency_valid", 32'(log_flag), 32'h1);
      idle(3);
    end
    check("opcodes_done_cnt", 32'(done_cnt), 32'h8);

    // Back-to-back stream of 8 operations.
    do_reset(1);
    max_run = 0;
    begin
      int t0;
      t0 = cyc;
      for (int i = 0; i < 8; i++) send(16'hF0F0, 16'hFF00, 3'(i), op_tab[i]);
      check("stream_accept_cycles", 32'(cyc - t0), 32'd8);
    end
    idle(4);
    check("stream_consecutive", 32'(max_run), 32'd8);
    check("stream_done_cnt", 32'(done_cnt), 32'h8);

    // Backpressure: two accepted, third refused until downstream ready.
    do_reset(1);
    out_ready = 1'b0;
    A = 16'hF0F0; B = 16'hFF00; alu_fun = 3'b100; log_EN = 1'b1;
    @(negedge clk);
    check("bp_in_ready_1", 32'(in_ready), 32'h1);
    sb.push_back(mk(16'h0FF0));
    @(posedge clk); #1;
    alu_fun = 3'b011;
    @(negedge clk);
    check("bp_in_ready_2", 32'(in_ready), 32'h1);
    sb.push_back(mk(16'h000F));
    @(posedge clk); #1;
    alu_fun = 3'b110;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready_3_blocked", 32'(in_ready), 32'h0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_3_open", 32'(in_ready), 32'h1);
    sb.push_back(mk(16'h0F0F));
    @(posedge clk); #1;
    log_EN = 1'b0;
    @(negedge clk);
    check("bp_occupancy_flag", 32'(log_flag), 32'h1);
    check("bp_done_cnt_1", 32'(done_cnt), 32'h1);
    idle(4);
    check("bp_done_cnt_3", 32'(done_cnt), 32'h3);

    // Status flags.
    send(16'h00FF, 16'hFF00, 3'b000, 16'h0000);
    send(16'h0001, 16'h0000, 3'b001, 16'h0001);
    idle(4);

    // Reset with two operations in flight.
    out_ready = 1'b0;
    send(16'h1234, 16'h00FF, 3'b000, 16'h0034);
    send(16'h1234, 16'h00FF, 3'b100, 16'h12CB);
    rest = 1'b1;
    @(posedge clk); #1;
    rest = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midrst_log_flag", 32'(log_flag), 32'h0);
    check("midrst_done_cnt", 32'(done_cnt), 32'h0);
    check("midrst_in_ready", 32'(in_ready), 32'h1);
    out_ready = 1'b1;
    idle(4);
    check("midrst_no_stale", 32'(done_cnt), 32'h0);

    // Counter wrap on the narrow-counter instance.
    for (int i = 0; i < 17; i++) send(16'hF0F0, 16'hFF00, 3'b000, 16'hF000);
    idle(4);
    check("wrap_done_cnt4", 32'(done_cnt4), 32'h1);
    check("wrap_done_cnt16", 32'(done_cnt), 32'd17);
    check("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
